pe_pass_scheduler: RTL and testbench

Synchronous sequencer for the 12-row PE array of the row-stationary datapath. It accepts one layer configuration through a valid/ready handshake and partitions the array into PE sets. It then loads filters once and loads ifmap rows set by set. For every output column pass it issues a start pulse and waits for the PE completion pulse, repeating until all ifm_width-filter_width+1 column passes are done.

---
 rtl/pe_pass_scheduler_pkg.sv | 40 ++++
 rtl/pe_pass_scheduler_if.sv | 49 ++++
 rtl/pe_pass_scheduler_partition.sv | 42 ++++
 rtl/pe_pass_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_pe_pass_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pass_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pass_scheduler_pkg
//  Description : Shared constants, state encoding and configuration record
//                for the row-stationary PE pass scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_pass_scheduler_pkg;

    localparam int PE_ROWS = 12;
    localparam int DEF_CW  = 16;

    // Counter / product widths for the derived layer quantities
    localparam int NF_W   = 15;
    localparam int NI_W   = 10;
    localparam int NSET_W = 10;
    localparam int USED_W = 15;

    // Scheduler states
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_LOAD_FILT = 3'd1;
    localparam state_t ST_LOAD_IFM  = 3'd2;
    localparam state_t ST_RUN       = 3'd3;
    localparam state_t ST_WAIT      = 3'd4;
    localparam state_t ST_FINISH    = 3'd5;

    // Layer configuration as offered on the handshake
    typedef struct packed {
        logic [4:0]        fh;
        logic [4:0]        fw;
        logic [4:0]        ic;
        logic [4:0]        oc;
        logic [4:0]        icb;
        logic [4:0]        ocb;
        logic [DEF_CW-1:0] ifm_width;
    } cfg_t;

endpackage
`default_nettype wire

// File: rtl/pe_pass_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pass_scheduler_if
//  Description : Configuration handshake plus PE-array control bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pe_pass_scheduler_if
    import pe_pass_scheduler_pkg::*;
#(
    parameter int ROWS = PE_ROWS,
    parameter int CW   = DEF_CW
);
    logic            cfg_valid;
    logic            cfg_ready;
    logic [4:0]      filter_height;
    logic [4:0]      filter_width;
    logic [4:0]      ic;
    logic [4:0]      oc;
    logic [4:0]      icb;
    logic [4:0]      ocb;
    logic [CW-1:0]   ifm_width;
    logic            complete;
    logic [ROWS-1:0] load_signal;
    logic [ROWS-1:0] load_signal2;
    logic [ROWS-1:0] load_signal3;
    logic [ROWS-2:0] mux_sel;
    logic            start;
    logic            busy;
    logic            done;
    logic            cfg_err;

    // Controller / environment side
    modport master (
        output cfg_valid, filter_height, filter_width, ic, oc, icb, ocb,
               ifm_width, complete,
        input  cfg_ready, load_signal, load_signal2, load_signal3, mux_sel,
               start, busy, done, cfg_err
    );

    // Scheduler side
    modport slave (
        input  cfg_valid, filter_height, filter_width, ic, oc, icb, ocb,
               ifm_width, complete,
        output cfg_ready, load_signal, load_signal2, load_signal3, mux_sel,
               start, busy, done, cfg_err
    );

endinterface
`default_nettype wire

// File: rtl/pe_pass_scheduler_partition.sv
`default_nettype none
// ============================================================================
//  Module      : pe_set_partition
//  Description : Pure combinational mapping from fh/icb/ocb to the used-row
//                mask, psum boundary selects and the first PE-set row mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_set_partition
    import pe_pass_scheduler_pkg::*;
#(
    parameter int ROWS = PE_ROWS
) (
    input  logic [4:0]        fh,
    input  logic [4:0]        icb,
    input  logic [4:0]        ocb,
    output logic [USED_W-1:0] used,
    output logic [ROWS-1:0]   used_mask,
    output logic [ROWS-2:0]   mux_sel,
    output logic [ROWS-1:0]   set_mask
);

    // Rows stacked per output-channel group: one psum chain spans fh*icb rows
    logic [9:0] w_grp;
    assign w_grp = 10'(fh) * 10'(icb);
    assign used  = USED_W'(w_grp) * USED_W'(ocb);

    // Per-row masks: rows in use, and rows belonging to PE set 0
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        assign used_mask[i] = (USED_W'(i) < used);
        assign set_mask[i]  = (USED_W'(i) < USED_W'(fh));
    end

    // Cut the psum chain at the top of every group except past the last used row
    for (genvar i = 0; i < ROWS - 1; i++) begin : g_bnd
        localparam logic [USED_W-1:0] c_pos = USED_W'(i + 1);
        assign mux_sel[i] = (w_grp != '0)
                         && ((c_pos % USED_W'(w_grp)) == '0)
                         && (c_pos < used);
    end

endmodule
`default_nettype wire

// File: rtl/pe_pass_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pass_scheduler
//  Description : Accepts a layer configuration, loads filters once, then for
//                every output column pass loads ifmap rows set by set, issues
//                start and waits for the PE array completion pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_pass_scheduler
    import pe_pass_scheduler_pkg::*;
#(
    parameter int ROWS = PE_ROWS,
    parameter int CW   = DEF_CW
) (
    input  logic              clk,
    input  logic              rst,
    pe_pass_scheduler_if.slave bus
);

    cfg_t              w_cfg;
    logic [USED_W-1:0] w_used;
    logic [ROWS-1:0]   w_used_mask;
    logic [ROWS-2:0]   w_mux_sel;
    logic [ROWS-1:0]   w_set_mask;
    logic              w_cfg_ok;
    logic              w_accept;

    state_t            r_state,  w_state_nxt;
    logic [NF_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [NSET_W-1:0] r_set,    w_set_nxt;
    logic [CW-1:0]     r_pass,   w_pass_nxt;

    logic [NF_W-1:0]   r_nf;
    logic [NI_W-1:0]   r_ni;
    logic [NSET_W-1:0] r_nset;
    logic [CW-1:0]     r_npass;
    logic [4:0]        r_fh;
    logic [ROWS-1:0]   r_used_mask;
    logic [ROWS-1:0]   r_set_mask;
    logic [ROWS-2:0]   r_mux_sel;

    logic              r_cfg_ready;
    logic              r_busy;
    logic              r_start;
    logic              r_done;
    logic              r_cfg_err;
    logic [ROWS-1:0]   r_load;
    logic [ROWS-1:0]   r_load2;
    logic [ROWS-1:0]   r_load3;

    logic [ROWS-1:0]   w_mask_cur;
    logic [ROWS-1:0]   w_ifm_mask;

    // Gather the configuration fields into one record
    always_comb begin
        w_cfg           = '0;
        w_cfg.fh        = bus.filter_height;
        w_cfg.fw        = bus.filter_width;
        w_cfg.ic        = bus.ic;
        w_cfg.oc        = bus.oc;
        w_cfg.icb       = bus.icb;
        w_cfg.ocb       = bus.ocb;
        w_cfg.ifm_width = bus.ifm_width;
    end

    pe_set_partition #(.ROWS(ROWS)) u_partition (
        .fh        (w_cfg.fh),
        .icb       (w_cfg.icb),
        .ocb       (w_cfg.ocb),
        .used      (w_used),
        .used_mask (w_used_mask),
        .mux_sel   (w_mux_sel),
        .set_mask  (w_set_mask)
    );

    assign w_accept = bus.cfg_valid && r_cfg_ready;
    assign w_cfg_ok = (w_cfg.fh != 5'd0)
                   && (USED_W'(w_cfg.fh) <= USED_W'(ROWS))
                   && (w_cfg.fw  != 5'd0) && (w_cfg.ic  != 5'd0)
                   && (w_cfg.oc  != 5'd0) && (w_cfg.icb != 5'd0)
                   && (w_cfg.ocb != 5'd0)
                   && (w_used <= USED_W'(ROWS))
                   && (CW'(w_cfg.ifm_width) >= CW'(w_cfg.fw));

    // Next-state and phase counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_set_nxt   = r_set;
        w_pass_nxt  = r_pass;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_cfg_ok) begin
                    w_state_nxt = ST_LOAD_FILT;
                    w_cnt_nxt   = '0;
                    w_set_nxt   = '0;
                    w_pass_nxt  = '0;
                end
            end
            ST_LOAD_FILT: begin
                if (r_cnt == r_nf - NF_W'(1)) begin
                    w_state_nxt = ST_LOAD_IFM;
                    w_cnt_nxt   = '0;
                    w_set_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + NF_W'(1);
                end
            end
            ST_LOAD_IFM: begin
                if (r_cnt == NF_W'(r_ni) - NF_W'(1)) begin
                    w_cnt_nxt = '0;
                    if (r_set == r_nset - NSET_W'(1)) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_set_nxt   = r_set + NSET_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + NF_W'(1);
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.complete) begin
                    w_pass_nxt = r_pass + CW'(1);
                    if (w_pass_nxt == r_npass) begin
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_state_nxt = ST_LOAD_IFM;
                        w_cnt_nxt   = '0;
                        w_set_nxt   = '0;
                    end
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Filter load is entered straight from the accept cycle, before the mask is latched
    assign w_mask_cur = (r_state == ST_IDLE) ? w_used_mask : r_used_mask;
    assign w_ifm_mask = r_set_mask << (NF_W'(w_set_nxt) * NF_W'(r_fh));

    // Latch derived layer quantities on a successful accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nf        <= '0;
            r_ni        <= '0;
            r_nset      <= '0;
            r_npass     <= '0;
            r_fh        <= '0;
            r_used_mask <= '0;
            r_set_mask  <= '0;
            r_mux_sel   <= '0;
        end else if (w_accept && w_cfg_ok) begin
            r_nf        <= NF_W'(w_cfg.fw) * NF_W'(w_cfg.oc) * NF_W'(w_cfg.ic);
            r_ni        <= NI_W'(w_cfg.fw) * NI_W'(w_cfg.ic);
            r_nset      <= NSET_W'(w_cfg.icb) * NSET_W'(w_cfg.ocb);
            r_npass     <= CW'(w_cfg.ifm_width) - CW'(w_cfg.fw) + CW'(1);
            r_fh        <= w_cfg.fh;
            r_used_mask <= w_used_mask;
            r_set_mask  <= w_set_mask;
            r_mux_sel   <= w_mux_sel;
        end
    end

    // State, counters and registered Moore outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_set       <= '0;
            r_pass      <= '0;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_start     <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_load      <= '0;
            r_load2     <= '0;
            r_load3     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_set       <= w_set_nxt;
            r_pass      <= w_pass_nxt;
            r_cfg_ready <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_start     <= (w_state_nxt == ST_RUN);
            r_done      <= (w_state_nxt == ST_FINISH);
            r_cfg_err   <= w_accept && !w_cfg_ok;
            r_load      <= ((w_state_nxt == ST_LOAD_FILT) || (w_state_nxt == ST_LOAD_IFM))
                           ? w_mask_cur : '0;
            r_load2     <= (w_state_nxt == ST_LOAD_IFM)  ? w_ifm_mask : '0;
            r_load3     <= (w_state_nxt == ST_LOAD_FILT) ? w_mask_cur : '0;
        end
    end

    assign bus.cfg_ready    = r_cfg_ready;
    assign bus.busy         = r_busy;
    assign bus.start        = r_start;
    assign bus.done         = r_done;
    assign bus.cfg_err      = r_cfg_err;
    assign bus.load_signal  = r_load;
    assign bus.load_signal2 = r_load2;
    assign bus.load_signal3 = r_load3;
    assign bus.mux_sel      = r_mux_sel;

endmodule
`default_nettype wire

// File: tb/tb_pe_pass_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_pass_scheduler
//  Description : Self-checking bench; expected per-cycle behaviour is built
//                as a phase script from the layer arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_pass_scheduler;
    import pe_pass_scheduler_pkg::*;

    localparam int ROWS = 12;
    localparam int CW   = 16;
    localparam int VW   = 3 * ROWS + 5;

    logic clk = 1'b0;
    logic rst;

    pe_pass_scheduler_if #(.ROWS(ROWS), .CW(CW)) bus ();

    pe_pass_scheduler #(.ROWS(ROWS), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ROWS-1:0] ls;
        logic [ROWS-1:0] ls2;
        logic [ROWS-1:0] ls3;
        logic            st;
        logic            dn;
        logic            cmp;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [VW-1:0] got_vec();
        return {bus.load_signal, bus.load_signal2, bus.load_signal3,
                bus.start, bus.done, bus.busy, bus.cfg_ready, bus.cfg_err};
    endfunction

    function automatic logic [VW-1:0] idle_vec(input logic err);
        return {{(3*ROWS+3){1'b0}}, 1'b1, err};
    endfunction

    function automatic exp_t mk(input logic [ROWS-1:0] ls, input logic [ROWS-1:0] ls2,
                                input logic [ROWS-1:0] ls3, input logic st,
                                input logic dn, input logic cmp);
        exp_t e;
        e.ls = ls; e.ls2 = ls2; e.ls3 = ls3; e.st = st; e.dn = dn; e.cmp = cmp;
        return e;
    endfunction

    // 0: never pulse complete outside WAIT, 1: random, 2: always
    function automatic logic pick_cmp(input int noise);
        if (noise == 2) return 1'b1;
        if (noise == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    function automatic logic [ROWS-2:0] exp_mux(input cfg_t c);
        logic [ROWS-2:0] m;
        int grp, used;
        grp  = int'(c.fh) * int'(c.icb);
        used = grp * int'(c.ocb);
        m = '0;
        for (int i = 0; i < ROWS - 1; i++)
            m[i] = ((i + 1) % grp == 0) && (i + 1 < used);
        return m;
    endfunction

    function automatic cfg_t mkcfg(input int fh, input int fw, input int ic, input int oc,
                                   input int icb, input int ocb, input int ifm);
        cfg_t c;
        c.fh = 5'(fh); c.fw = 5'(fw); c.ic = 5'(ic); c.oc = 5'(oc);
        c.icb = 5'(icb); c.ocb = 5'(ocb); c.ifm_width = 16'(ifm);
        return c;
    endfunction

    function automatic cfg_t rand_legal();
        int fh, icb, ocb, fw;
        do begin
            fh  = $urandom_range(1, 12);
            icb = $urandom_range(1, 4);
            ocb = $urandom_range(1, 3);
        end while (fh * icb * ocb > 12);
        fw = $urandom_range(1, 3);
        return mkcfg(fh, fw, $urandom_range(1, 2), $urandom_range(1, 2), icb, ocb,
                     fw + $urandom_range(0, 3));
    endfunction

    task automatic drive_cfg(input cfg_t c);
        bus.filter_height = c.fh;
        bus.filter_width  = c.fw;
        bus.ic            = c.ic;
        bus.oc            = c.oc;
        bus.icb           = c.icb;
        bus.ocb           = c.ocb;
        bus.ifm_width     = c.ifm_width;
    endtask

    // Expected cycle script from accept+1 through the FINISH cycle
    task automatic build(input cfg_t c, input int noise);
        int nf, ni, nset, npass, used, w;
        logic [ROWS-1:0] um, fm;
        nf    = int'(c.fw) * int'(c.oc) * int'(c.ic);
        ni    = int'(c.fw) * int'(c.ic);
        nset  = int'(c.icb) * int'(c.ocb);
        npass = int'(c.ifm_width) - int'(c.fw) + 1;
        used  = int'(c.fh) * int'(c.icb) * int'(c.ocb);
        um    = ROWS'((1 << used) - 1);
        fm    = ROWS'((1 << int'(c.fh)) - 1);
        q.delete();
        for (int i = 0; i < nf; i++) q.push_back(mk(um, '0, um, 1'b0, 1'b0, pick_cmp(noise)));
        for (int p = 0; p < npass; p++) begin
            for (int k = 0; k < nset; k++)
                for (int i = 0; i < ni; i++)
                    q.push_back(mk(um, ROWS'(int'(fm) << (k * int'(c.fh))), '0,
                                   1'b0, 1'b0, pick_cmp(noise)));
            q.push_back(mk('0, '0, '0, 1'b1, 1'b0, pick_cmp(noise)));
            w = $urandom_range(0, 3);
            for (int i = 0; i < w; i++) q.push_back(mk('0, '0, '0, 1'b0, 1'b0, 1'b0));
            q.push_back(mk('0, '0, '0, 1'b0, 1'b0, 1'b1));
        end
        q.push_back(mk('0, '0, '0, 1'b0, 1'b1, pick_cmp(noise)));
    endtask

    // Runs one layer; entered and left at 1 time unit after a rising edge
    task automatic run_layer(input string name, input cfg_t c, input int noise,
                             input bit hold, input cfg_t nxt);
        logic [VW-1:0] g, e;
        build(c, noise);
        drive_cfg(c);
        bus.cfg_valid = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL %s accept: ready=%b busy=%b expected ready=1 busy=0",
                     name, bus.cfg_ready, bus.busy);
        else n_pass++;
        @(posedge clk); #1;
        if (hold) drive_cfg(nxt);
        else begin
            bus.cfg_valid = 1'b0;
            drive_cfg(mkcfg($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                            $urandom_range(0, 65535)));
        end
        for (int j = 0; j < q.size(); j++) begin
            bus.complete = q[j].cmp;
            @(negedge clk);
            if (j == 0) begin
                n_chk++;
                if (bus.mux_sel !== exp_mux(c))
                    $display("FAIL %s mux_sel: got %b expected %b", name, bus.mux_sel, exp_mux(c));
                else n_pass++;
            end
            g = got_vec();
            e = {q[j].ls, q[j].ls2, q[j].ls3, q[j].st, q[j].dn, 1'b1, 1'b0, 1'b0};
            n_chk++;
            if (g !== e)
                $display("FAIL %s cycle %0d: got %h expected %h", name, j, g, e);
            else n_pass++;
            @(posedge clk); #1;
        end
        bus.complete = 1'b0;
        if (!hold) begin
            @(negedge clk);
            n_chk++;
            if (got_vec() !== idle_vec(1'b0))
                $display("FAIL %s post_idle: got %h expected %h", name, got_vec(), idle_vec(1'b0));
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.complete  = 1'b0;
        drive_cfg(mkcfg(0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_chk++;
        if (got_vec() !== idle_vec(1'b0) || bus.mux_sel !== '0)
            $display("FAIL reset_state: got %h mux %b expected %h mux 0",
                     got_vec(), bus.mux_sel, idle_vec(1'b0));
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        cfg_t c;
        c = mkcfg(3, 3, 1, 1, 2, 2, 5);
        run_layer("basic", c, 0, 1'b0, c);
        n_chk++;
        if (bus.mux_sel !== 11'b000_0010_0000)
            $display("FAIL basic_mux_hold: got %b expected 00000100000", bus.mux_sel);
        else n_pass++;
    endtask

    task automatic test_bad_cfg(input string name, input cfg_t c);
        drive_cfg(c);
        bus.cfg_valid = 1'b1;
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (got_vec() !== idle_vec(1'b1))
            $display("FAIL %s err_pulse: got %h expected %h", name, got_vec(), idle_vec(1'b1));
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_chk++;
            if (got_vec() !== idle_vec(1'b0))
                $display("FAIL %s after_err: got %h expected %h", name, got_vec(), idle_vec(1'b0));
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_complete();
        cfg_t c;
        c = mkcfg(3, 3, 1, 1, 2, 2, 5);
        run_layer("ignore_complete", c, 2, 1'b0, c);
    endtask

    task automatic test_reset_mid();
        drive_cfg(mkcfg(2, 2, 1, 1, 1, 1, 4));
        bus.cfg_valid = 1'b1;
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.load_signal2 !== 12'h003)
            $display("FAIL reset_mid_pre: got %h expected 003", bus.load_signal2);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (got_vec() !== idle_vec(1'b0) || bus.mux_sel !== '0)
            $display("FAIL reset_mid_post: got %h mux %b expected %h mux 0",
                     got_vec(), bus.mux_sel, idle_vec(1'b0));
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_chk++;
            if (got_vec() !== idle_vec(1'b0))
                $display("FAIL reset_mid_idle: got %h expected %h", got_vec(), idle_vec(1'b0));
            else n_pass++;
        end
        @(posedge clk); #1;
        run_layer("after_reset", rand_legal(), 1, 1'b0, rand_legal());
    endtask

    task automatic test_single_pass();
        cfg_t c;
        c = mkcfg(12, 3, 2, 1, 1, 1, 3);
        run_layer("single_pass", c, 1, 1'b0, c);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            run_layer("random", rand_legal(), 1, 1'b0, rand_legal());
    endtask

    task automatic test_back_to_back();
        cfg_t a, b;
        a = mkcfg(3, 3, 1, 1, 2, 2, 5);
        b = mkcfg(2, 2, 2, 1, 1, 3, 4);
        run_layer("b2b_first", a, 1, 1'b1, b);
        run_layer("b2b_second", b, 1, 1'b0, b);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_cfg("bad_used",  mkcfg(5, 3, 1, 1, 2, 2, 8));
        test_bad_cfg("bad_fw0",   mkcfg(2, 0, 1, 1, 1, 1, 4));
        test_bad_cfg("bad_ifm",   mkcfg(2, 4, 1, 1, 1, 1, 3));
        test_bad_cfg("bad_fh13",  mkcfg(13, 1, 1, 1, 1, 1, 4));
        test_bad_cfg("bad_ic0",   mkcfg(2, 2, 0, 1, 1, 1, 4));
        test_ignore_complete();
        test_reset_mid();
        test_single_pass();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
